// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch controller.
// No logic; compile-time definitions only.
// Not applicable (no handshake).
package fetch_pkg;

    typedef enum logic {
        IDLE        = 1'b0,
        BRANCH_WAIT = 1'b1
    } pf_state_e;

    // Clears the byte offset so every fetch address is word aligned.
    localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/prefetch_ctrl_if.sv
// Bus, FIFO-side and aligner-side signals of the prefetch controller.
// Wires only; no latency.
// valid/ready on the bus request and on the fetch output.
interface prefetch_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             trans_valid_o;
    logic             trans_ready_i;
    logic [31:0]      trans_addr_o;
    logic             resp_valid_i;
    logic [31:0]      resp_rdata_i;
    logic [CNT_W-1:0] fifo_cnt_i;
    logic             fifo_empty_i;
    logic [31:0]      fifo_rdata_i;
    logic             fifo_push_o;
    logic             fifo_pop_o;
    logic             fifo_flush_o;
    logic             fetch_valid_o;
    logic [31:0]      fetch_rdata_o;
    logic             fetch_ready_i;

    // Controller side.
    modport master (
        output trans_valid_o, trans_addr_o, fifo_push_o, fifo_pop_o,
               fifo_flush_o, fetch_valid_o, fetch_rdata_o,
        input  trans_ready_i, resp_valid_i, resp_rdata_i, fifo_cnt_i,
               fifo_empty_i, fifo_rdata_i, fetch_ready_i
    );

    // Bus / FIFO / aligner side.
    modport slave (
        input  trans_valid_o, trans_addr_o, fifo_push_o, fifo_pop_o,
               fifo_flush_o, fetch_valid_o, fetch_rdata_o,
        output trans_ready_i, resp_valid_i, resp_rdata_i, fifo_cnt_i,
               fifo_empty_i, fifo_rdata_i, fetch_ready_i
    );
endinterface

// File: rtl/prefetch_ctrl.sv
// Instruction prefetch controller: issues word fetches, tracks outstanding, feeds FIFO/aligner.
// Request is combinational; response reaches fetch output in 0 cycles when FIFO empty and ready.
// New requests stall while outstanding + FIFO occupancy reaches DEPTH; branch requests hold until accepted.
module prefetch_ctrl
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  branch_i,
    input  logic [31:0]           branch_addr_i,
    output logic                  busy_o,
    prefetch_ctrl_if.master       bus
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    pf_state_e        state_q, state_d;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] outst_q;
    logic [CNT_W-1:0] flush_q;

    logic             trans_valid;
    logic [31:0]      trans_addr;
    logic             hs;
    logic             del;
    logic [31:0]      branch_tgt;
    logic [CNT_W:0]   occupancy;

    assign branch_tgt = branch_addr_i & FETCH_ALIGN_MASK;
    // Extra bit so outstanding + FIFO count cannot wrap when both are full.
    assign occupancy  = {1'b0, outst_q} + {1'b0, bus.fifo_cnt_i};

    // Next state and bus request. A branch arriving while already waiting
    // drives the new target immediately, so an acceptance in that cycle
    // fetches the new target rather than the stale one.
    always_comb begin
        state_d     = state_q;
        trans_valid = 1'b0;
        trans_addr  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (branch_i) begin
                    trans_valid = (outst_q < DEPTH_C);
                    trans_addr  = branch_tgt;
                    if (!(trans_valid && bus.trans_ready_i)) begin
                        state_d = BRANCH_WAIT;
                    end
                end else begin
                    trans_valid = req_i && (occupancy < DEPTH_W);
                end
            end
            BRANCH_WAIT: begin
                trans_valid = 1'b1;
                if (branch_i) begin
                    trans_addr = branch_tgt;
                end
                if (bus.trans_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs  = trans_valid && bus.trans_ready_i;
    // Responses still owed to pre-branch requests are dropped.
    assign del = bus.resp_valid_i && (flush_q == '0) && !branch_i;

    assign bus.trans_valid_o = trans_valid;
    assign bus.trans_addr_o  = trans_addr;
    assign bus.fetch_valid_o = !branch_i && (!bus.fifo_empty_i || del);
    assign bus.fetch_rdata_o = bus.fifo_empty_i ? bus.resp_rdata_i : bus.fifo_rdata_i;
    assign bus.fifo_pop_o    = !branch_i && !bus.fifo_empty_i && bus.fetch_ready_i;
    assign bus.fifo_push_o   = del && (!bus.fifo_empty_i || !bus.fetch_ready_i);
    assign bus.fifo_flush_o  = branch_i;
    assign busy_o            = (outst_q != '0) || trans_valid;

    // State, fetch address, outstanding and flush counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            outst_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;

            if (hs) begin
                addr_q <= trans_addr + 32'd4;
            end else if (branch_i) begin
                addr_q <= branch_tgt;
            end

            unique case ({hs, bus.resp_valid_i})
                2'b10:   outst_q <= outst_q + ONE_C;
                2'b01:   outst_q <= outst_q - ONE_C;
                default: outst_q <= outst_q;
            endcase

            if (branch_i) begin
                flush_q <= outst_q - {{(CNT_W-1){1'b0}}, bus.resp_valid_i};
            end else if (bus.resp_valid_i && (flush_q != '0)) begin
                flush_q <= flush_q - ONE_C;
            end
        end
    end

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Directed self-checking bench for prefetch_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Bus, FIFO and aligner behaviour is driven directly by each scenario.
module tb_prefetch_ctrl;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        branch;
    logic [31:0] branch_addr;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prefetch_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

    prefetch_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .branch_i      (branch),
        .branch_addr_i (branch_addr),
        .busy_o        (busy),
        .bus           (bus_if.master)
    );

    task automatic idle_inputs();
        req                  = 1'b0;
        branch               = 1'b0;
        branch_addr          = 32'h0;
        bus_if.trans_ready_i = 1'b0;
        bus_if.resp_valid_i  = 1'b0;
        bus_if.resp_rdata_i  = 32'h0;
        bus_if.fifo_cnt_i    = '0;
        bus_if.fifo_empty_i  = 1'b1;
        bus_if.fifo_rdata_i  = 32'h0;
        bus_if.fetch_ready_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        step();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        checks++; if (bus_if.trans_valid_o !== 1'b0) begin failures++; $display("FAIL rst_trans_valid got=%0h exp=0", bus_if.trans_valid_o); end
        checks++; if (bus_if.trans_addr_o !== 32'h0) begin failures++; $display("FAIL rst_trans_addr got=%0h exp=0", bus_if.trans_addr_o); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (bus_if.fetch_valid_o !== 1'b0) begin failures++; $display("FAIL rst_fetch_valid got=%0h exp=0", bus_if.fetch_valid_o); end
        checks++; if ({bus_if.fifo_push_o, bus_if.fifo_pop_o, bus_if.fifo_flush_o} !== 3'b000) begin failures++; $display("FAIL rst_fifo_ctl got=%0b exp=000", {bus_if.fifo_push_o, bus_if.fifo_pop_o, bus_if.fifo_flush_o}); end
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++; if ({busy, bus_if.trans_valid_o} !== 2'b00) begin failures++; $display("FAIL post_rst_idle got=%0b exp=00", {busy, bus_if.trans_valid_o}); end
    endtask

    task automatic test_capacity();
        logic [31:0] exp_addr;
        do_reset();
        req = 1'b1;
        bus_if.trans_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_addr = 32'(i * 4);
            #1;
            checks++; if (bus_if.trans_valid_o !== 1'b1) begin failures++; $display("FAIL cap_valid[%0d] got=%0h exp=1", i, bus_if.trans_valid_o); end
            checks++; if (bus_if.trans_addr_o !== exp_addr) begin failures++; $display("FAIL cap_addr[%0d] got=%0h exp=%0h", i, bus_if.trans_addr_o, exp_addr); end
            step();
        end
        #1;
        checks++; if (bus_if.trans_valid_o !== 1'b0) begin failures++; $display("FAIL cap_block got=%0h exp=0", bus_if.trans_valid_o); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cap_busy got=%0h exp=1", busy); end
        idle_inputs();
    endtask

    task automatic test_branch_flush();
        do_reset();
        req = 1'b1;
        bus_if.trans_ready_i = 1'b1;
        step();
        step();
        // Two requests outstanding; redirect.
        branch = 1'b1;
        branch_addr = 32'h0000_0103;
        #1;
        checks++; if (bus_if.trans_addr_o !== 32'h100) begin failures++; $display("FAIL br_addr got=%0h exp=100", bus_if.trans_addr_o); end
        checks++; if ({bus_if.trans_valid_o, bus_if.fifo_flush_o} !== 2'b11) begin failures++; $display("FAIL br_valid_flush got=%0b exp=11", {bus_if.trans_valid_o, bus_if.fifo_flush_o}); end
        step();
        branch = 1'b0;
        req = 1'b0;
        bus_if.trans_ready_i = 1'b0;
        bus_if.fetch_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus_if.resp_valid_i = 1'b1;
            bus_if.resp_rdata_i = 32'hBAD0_0000 + 32'(i);
            #1;
            checks++; if ({bus_if.fifo_push_o, bus_if.fetch_valid_o} !== 2'b00) begin failures++; $display("FAIL br_drop[%0d] got=%0b exp=00", i, {bus_if.fifo_push_o, bus_if.fetch_valid_o}); end
            step();
        end
        bus_if.resp_rdata_i = 32'h1234_5678;
        #1;
        checks++; if (bus_if.fetch_valid_o !== 1'b1) begin failures++; $display("FAIL br_deliver_valid got=%0h exp=1", bus_if.fetch_valid_o); end
        checks++; if (bus_if.fetch_rdata_o !== 32'h1234_5678) begin failures++; $display("FAIL br_deliver_data got=%0h exp=12345678", bus_if.fetch_rdata_o); end
        step();
        idle_inputs();
    endtask

    task automatic test_fall_through();
        do_reset();
        req = 1'b1;
        bus_if.trans_ready_i = 1'b1;
        step();
        step();
        req = 1'b0;
        bus_if.trans_ready_i = 1'b0;
        bus_if.fetch_ready_i = 1'b1;
        bus_if.resp_valid_i = 1'b1;
        bus_if.resp_rdata_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus_if.fetch_valid_o !== 1'b1) begin failures++; $display("FAIL ft_valid got=%0h exp=1", bus_if.fetch_valid_o); end
        checks++; if (bus_if.fetch_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ft_data got=%0h exp=deadbeef", bus_if.fetch_rdata_o); end
        checks++; if (bus_if.fifo_push_o !== 1'b0) begin failures++; $display("FAIL ft_push got=%0h exp=0", bus_if.fifo_push_o); end
        step();
        // Aligner stalled: the same response must be pushed instead.
        bus_if.fetch_ready_i = 1'b0;
        bus_if.resp_rdata_i = 32'hCAFE_F00D;
        #1;
        checks++; if ({bus_if.fifo_push_o, bus_if.fifo_pop_o} !== 2'b10) begin failures++; $display("FAIL ft_stall_push got=%0b exp=10", {bus_if.fifo_push_o, bus_if.fifo_pop_o}); end
        step();
        idle_inputs();
    endtask

    task automatic test_branch_wait();
        do_reset();
        branch = 1'b1;
        branch_addr = 32'h0000_0200;
        #1;
        checks++; if ({bus_if.trans_valid_o, bus_if.fifo_flush_o} !== 2'b11) begin failures++; $display("FAIL bw_first got=%0b exp=11", {bus_if.trans_valid_o, bus_if.fifo_flush_o}); end
        step();
        branch = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (dut.state_q !== BRANCH_WAIT) begin failures++; $display("FAIL bw_state[%0d] got=%0h exp=%0h", i, dut.state_q, BRANCH_WAIT); end
            checks++; if ({bus_if.trans_valid_o, bus_if.trans_addr_o} !== {1'b1, 32'h200}) begin failures++; $display("FAIL bw_hold[%0d] got=%0b/%0h exp=1/200", i, bus_if.trans_valid_o, bus_if.trans_addr_o); end
            step();
        end
        branch = 1'b1;
        branch_addr = 32'h0000_0300;
        step();
        branch = 1'b0;
        #1;
        checks++; if (dut.state_q !== BRANCH_WAIT) begin failures++; $display("FAIL bw_rebranch_state got=%0h exp=%0h", dut.state_q, BRANCH_WAIT); end
        checks++; if (bus_if.trans_addr_o !== 32'h300) begin failures++; $display("FAIL bw_rebranch_addr got=%0h exp=300", bus_if.trans_addr_o); end
        bus_if.trans_ready_i = 1'b1;
        req = 1'b1;
        step();
        #1;
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL bw_back_idle got=%0h exp=%0h", dut.state_q, IDLE); end
        checks++; if ({bus_if.trans_valid_o, bus_if.trans_addr_o} !== {1'b1, 32'h304}) begin failures++; $display("FAIL bw_next got=%0b/%0h exp=1/304", bus_if.trans_valid_o, bus_if.trans_addr_o); end
        step();
        idle_inputs();
    endtask

    task automatic test_addr_wrap();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        do_reset();
        req = 1'b1;
        bus_if.trans_ready_i = 1'b1;
        branch = 1'b1;
        branch_addr = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({bus_if.trans_valid_o, bus_if.trans_addr_o} !== {1'b1, exp_addr[i]}) begin failures++; $display("FAIL wrap[%0d] got=%0b/%0h exp=1/%0h", i, bus_if.trans_valid_o, bus_if.trans_addr_o, exp_addr[i]); end
            step();
            branch = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 1'b1;
        bus_if.trans_ready_i = 1'b1;
        step();
        // One outstanding plus three in the FIFO fills the budget.
        bus_if.fifo_cnt_i    = 3'd3;
        bus_if.fifo_empty_i  = 1'b0;
        bus_if.fifo_rdata_i  = 32'h0000_AAAA;
        bus_if.fetch_ready_i = 1'b0;
        bus_if.resp_valid_i  = 1'b1;
        bus_if.resp_rdata_i  = 32'h0000_BBBB;
        #1;
        checks++; if (bus_if.trans_valid_o !== 1'b0) begin failures++; $display("FAIL bp_block got=%0h exp=0", bus_if.trans_valid_o); end
        checks++; if ({bus_if.fifo_push_o, bus_if.fifo_pop_o} !== 2'b10) begin failures++; $display("FAIL bp_push_pop got=%0b exp=10", {bus_if.fifo_push_o, bus_if.fifo_pop_o}); end
        checks++; if ({bus_if.fetch_valid_o, bus_if.fetch_rdata_o} !== {1'b1, 32'h0000_AAAA}) begin failures++; $display("FAIL bp_head got=%0b/%0h exp=1/aaaa", bus_if.fetch_valid_o, bus_if.fetch_rdata_o); end
        step();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_capacity();
        test_branch_flush();
        test_fall_through();
        test_branch_wait();
        test_addr_wrap();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prefetch_ctrl.md
# prefetch_ctrl

Instruction prefetch controller that sits directly upstream of the prefetch FIFO. It issues word-aligned OBI-style fetch requests, counts outstanding transactions, and pushes returned words into the FIFO. On a branch it discards responses that are still in flight. It also drives the fetch output to the aligner, either from the FIFO head or bypassed directly from the bus response.

## Interface
- DEPTH, 4: depth of the downstream FIFO; also the maximum of outstanding transactions plus FIFO occupancy.
- CNT_W, $clog2(DEPTH)+1: derived counter width; do not override.

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  fetching enabled
- branch_i  in  1  redirect fetch, single-cycle pulse
- branch_addr_i  in  32  branch target; bits [1:0] are ignored
- busy_o  out  1  outstanding transactions exist, or a request is pending
- trans_valid_o  out  1  bus request valid
- trans_ready_i  in  1  bus request accepted
- trans_addr_o  out  32  bus address; bits [1:0] are always 0
- resp_valid_i  in  1  bus response valid, in order, one per accepted request
- resp_rdata_i  in  32  bus response data
- fifo_cnt_i  in  CNT_W  FIFO occupancy
- fifo_empty_i  in  1  FIFO empty
- fifo_rdata_i  in  32  FIFO head data
- fifo_push_o  out  1  push resp_rdata_i into the FIFO
- fifo_pop_o  out  1  pop the FIFO head
- fifo_flush_o  out  1  flush the FIFO
- fetch_valid_o  out  1  instruction word valid to the aligner
- fetch_rdata_o  out  32  instruction word
- fetch_ready_i  in  1  aligner accepts the word

## Operation
- Registers: state_q, addr_q[31:0], outst_q[CNT_W], flush_q[CNT_W]. All reset to IDLE / 0.
- State machine:
  - IDLE
    - trans_valid_o = req_i & (outst_q + fifo_cnt_i < DEPTH).
    - With branch_i: trans_valid_o = outst_q < DEPTH, and trans_addr_o = {branch_addr_i[31:2],2'b00}.
    - Without branch_i: trans_addr_o = addr_q.
    - branch_i & ~(trans_valid_o & trans_ready_i) -> BRANCH_WAIT.
  - BRANCH_WAIT
    - trans_valid_o = 1; trans_addr_o = addr_q, which holds the latched target.
    - Accepted -> IDLE.
    - A new branch_i replaces the target and stays in BRANCH_WAIT.
- addr_q update, in priority order:
  - On handshake: addr_q <= trans_addr_o + 4, 32-bit wrap (0xFFFFFFFC -> 0).
  - Else on branch_i: addr_q <= aligned target.
- outst_q: +1 on handshake, -1 on resp_valid_i; both in the same cycle leaves it unchanged.
- Flushing:
  - On branch_i: flush_q <= outst_q - resp_valid_i. This covers every response to a pre-branch request that has not yet returned.
  - Otherwise, resp_valid_i with flush_q != 0 decrements flush_q, and that response is dropped.
- Deliver condition: del = resp_valid_i & (flush_q == 0) & ~branch_i.
- fetch_valid_o = ~branch_i & (~fifo_empty_i | del).
- fetch_rdata_o = fifo_empty_i ? resp_rdata_i : fifo_rdata_i. This is the fall-through path.
- fifo_pop_o = ~branch_i & ~fifo_empty_i & fetch_ready_i.
- fifo_push_o = del & (~fifo_empty_i | ~fetch_ready_i).
- fifo_flush_o = branch_i.
- busy_o = (outst_q != 0) | trans_valid_o.

## Timing
- After reset, every output is 0 until req_i or branch_i is asserted.
- Request issue is combinational from the inputs and registered state.
- Address increments one cycle after a handshake.
- Response to fetch output has zero latency when the FIFO is empty and fetch_ready_i=1.
- Otherwise a word appears on fetch_valid_o the cycle after it is pushed.
- Branch to first new request has zero cycles (same cycle) if the bus is ready. Otherwise trans_valid_o is held, with a stable address, until trans_ready_i.
- Outside branches, trans_valid_o is never retracted once asserted: pushes and responses leave outst_q+fifo_cnt_i unchanged or lower. req_i must stay high while a request is pending.
- Capacity limit: outst_q+fifo_cnt_i == DEPTH blocks new requests. The FIFO therefore never overflows.
- Reset asserted mid-operation: all state clears immediately. Responses to requests issued before reset are the bus's responsibility.

## Structure
- fetch_pkg holds:
  - the enum pf_state_e with values IDLE and BRANCH_WAIT;
  - the localparam FETCH_ALIGN_MASK = 32'hFFFF_FFFC.
- No sub-module. The FIFO is instantiated by the parent beside this block, with resp_rdata_i wired to its data input.

## Test plan
- Capacity limit: DEPTH=4, req_i=1, trans_ready_i=1, no responses -> handshakes at addresses 0x0, 0x4, 0x8, 0xC, then trans_valid_o=0 and busy_o=1.
- Branch flush: with outst_q=2, branch_i with branch_addr_i=0x103 -> trans_addr_o=0x100 and fifo_flush_o=1 the same cycle. The next 2 responses give no push and fetch_valid_o=0. The third response, 0x1234_5678, is delivered.
- Fall-through: FIFO empty, fetch_ready_i=1, resp_valid_i with 0xDEADBEEF -> fetch_valid_o=1 and fetch_rdata_o=0xDEADBEEF the same cycle; fifo_push_o=0.
- Branch wait: branch_i to 0x200 with trans_ready_i=0 for 3 cycles -> state BRANCH_WAIT and trans_addr_o=0x200 held. A second branch to 0x300 replaces the address with 0x300. Ready -> return to IDLE, then the next address is 0x304.
- Address wrap: branch to 0xFFFFFFF8 with the bus always ready -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Backpressure: fetch_ready_i=0, fifo_cnt_i=3, outst_q=1 -> trans_valid_o=0. The response is pushed, and no pop occurs.
